// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage sitting directly in front of the instruction
//   memory. Owns the PC, drives the memory byte address, captures the word the
//   memory returns in the same cycle into a small in-order queue and offers
//   {instruction, PC} to decode over a valid/ready handshake. A redirect
//   (taken branch/jump) reloads the PC and flushes the queue.
//
// Parameters
//   RESET_PC  word-aligned PC loaded on reset
//   DEPTH     fetch-queue entries (power of 2, >= 2)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous reset, active low
//   imem_addr       byte address to instruction memory (current PC)
//   imem_data       instruction word at imem_addr, same cycle
//   redirect_valid  taken branch/jump this cycle
//   redirect_pc     redirect target, bits [1:0] ignored
//   inst_valid      queue head holds a valid instruction
//   inst_ready      decode accepts the head this cycle
//   inst            head instruction word (0 when empty)
//   inst_pc         PC of the head instruction (0 when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Control state
  logic [31:0]      pc_q,     pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Queue storage: instruction word and the PC it was fetched from
  logic [31:0] word_q [DEPTH];
  logic [31:0] addr_q [DEPTH];

  logic pop;
  logic push;

  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != '0);

  // Empty queue presents zeros, so stale storage never leaks to decode.
  assign inst    = inst_valid ? word_q[rd_ptr_q] : 32'h0;
  assign inst_pc = inst_valid ? addr_q[rd_ptr_q] : 32'h0;

  assign pop  = inst_valid & inst_ready;
  // A full queue can still accept a new word when the head leaves this edge.
  assign push = ~redirect_valid & ((count_q < DEPTH_C) | pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (redirect_valid) begin
      // The same-cycle pop is already handed to decode; everything behind it
      // is discarded by snapping the read pointer onto the write pointer.
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset. An entry is only ever read after it
  // has been written (count_q guards the output mux), so resetting it would
  // buy nothing and would prevent mapping onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= imem_data;
      addr_q[wr_ptr_q] <= pc_q;
    end
  end

endmodule
